// File: rtl/bus_bridge_pkg.sv
// bus_bridge_pkg: shared types and constants for the 6502 bus bridge.
// Holds the bridge FSM state encoding, the A[15:13] region codes and the
// default read latency of the memory/IO block.
package bus_bridge_pkg;

    // Bridge FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // A[15:13] region codes
    localparam logic [2:0] REGION_ROM  = 3'b111;
    localparam logic [2:0] REGION_RAM  = 3'b000;
    localparam logic [2:0] REGION_UART = 3'b110;

    // Sync memory read plus registered output mux
    localparam int DEFAULT_READ_LAT = 3;

    // True when the address falls in the given 8 KiB region
    function automatic logic in_region(input logic [15:0] addr, input logic [2:0] region);
        return (addr[15:13] == region);
    endfunction

endpackage

// File: rtl/bus_bridge_phi2_edge.sv
// bus_bridge_phi2_edge: samples PHI2 in the CLK domain and produces
// registered single-CLK rise/fall pulses. PHI2 is generated synchronously
// to CLK, so no synchroniser stages are needed.
module bus_bridge_phi2_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic phi2_i,
    output logic rise_o,
    output logic fall_o
);

    logic phi2_q;
    logic rise_q;
    logic fall_q;

    // Register PHI2 and derive edge pulses against the previous sample
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            phi2_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            phi2_q <= phi2_i;
            rise_q <= phi2_i & ~phi2_q;
            fall_q <= ~phi2_i & phi2_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/bus_bridge.sv
// bus_bridge: launches exactly one IO access per 6502 PHI2 cycle.
// A PHI2 rise latches address/write data, a write becomes a one-CLK R_W_n
// strobe, and read data is captured READ_LAT CLKs after launch.
// Optional feature macro: WAIT_STATE_EN -- when defined, accesses whose
// A[15:13] equals WAIT_REGION are stretched by WAIT_CYCLES and the CPU is
// held through RDY; when undefined RDY stays 1 and every access uses
// READ_LAT only.
module bus_bridge
    import bus_bridge_pkg::*;
#(
    parameter int         READ_LAT    = DEFAULT_READ_LAT,
    parameter int         WAIT_CYCLES = 4,
    parameter logic [2:0] WAIT_REGION = REGION_UART
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        PHI2,
    input  logic [15:0] CPU_A,
    input  logic [7:0]  CPU_DO,
    input  logic        CPU_R_W_n,
    output logic [7:0]  CPU_DI,
    output logic        RDY,
    output logic [15:0] A,
    output logic [7:0]  DI,
    output logic        R_W_n,
    input  logic [7:0]  IO_DO,
    output logic        OVERRUN
);

    localparam int CNT_W = $clog2(READ_LAT + WAIT_CYCLES + 1);

`ifdef WAIT_STATE_EN
    localparam logic WAIT_EN = 1'b1;
`else
    localparam logic WAIT_EN = 1'b0;
`endif

    // Counter preloads: the launch cycle itself counts as the first latency cycle
    localparam logic [CNT_W-1:0] LOAD_BASE = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] LOAD_WAIT = CNT_W'(READ_LAT - 1 + WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             rise_s;
    logic             fall_s;
    logic             wait_hit_s;
    logic [CNT_W-1:0] cnt_load_s;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      a_q;
    logic [7:0]       di_q;
    logic [7:0]       cpu_di_q;
    logic             r_w_n_q;
    logic             rdy_q;
    logic             ovr_q;
    logic             wr_q;
    logic             late_q;

    bus_bridge_phi2_edge u_phi2_edge (
        .clk_i  (CLK),
        .rst_ni (RESET_n),
        .phi2_i (PHI2),
        .rise_o (rise_s),
        .fall_o (fall_s)
    );

    // Slow-region decode and counter preload for the access being launched
    always_comb begin
        wait_hit_s = WAIT_EN & in_region(CPU_A, WAIT_REGION);
        if (wait_hit_s) begin
            cnt_load_s = LOAD_WAIT;
        end else begin
            cnt_load_s = LOAD_BASE;
        end
    end

    // Access FSM: launch on rise, count latency, capture, wait for fall
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_ZERO;
            a_q      <= 16'h0000;
            di_q     <= 8'h00;
            cpu_di_q <= 8'h00;
            r_w_n_q  <= 1'b1;
            rdy_q    <= 1'b1;
            ovr_q    <= 1'b0;
            wr_q     <= 1'b0;
            late_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise_s) begin
                        a_q <= CPU_A;
                        if (!CPU_R_W_n) begin
                            di_q <= CPU_DO;
                        end
                        wr_q    <= ~CPU_R_W_n;
                        r_w_n_q <= CPU_R_W_n;
                        rdy_q   <= ~wait_hit_s;
                        cnt_q   <= cnt_load_s;
                        late_q  <= 1'b0;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Strobe lasts only the first ACCESS cycle
                    r_w_n_q <= 1'b1;
                    if (cnt_q == CNT_ZERO) begin
                        if (!wr_q) begin
                            cpu_di_q <= IO_DO;
                        end
                        rdy_q <= 1'b1;
                        // Fall already seen (early or right now): no fall left to wait for
                        if (late_q || fall_s) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                        if (fall_s) begin
                            ovr_q  <= 1'b1;
                            late_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (fall_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign A       = a_q;
    assign DI      = di_q;
    assign CPU_DI  = cpu_di_q;
    assign RDY     = rdy_q;
    assign OVERRUN = ovr_q;
    // Reset withdraws a write strobe immediately instead of one CLK later
    assign R_W_n   = r_w_n_q | ~RESET_n;

endmodule

// File: tb/tb_bus_bridge.sv
// tb_bus_bridge: directed test of bus_bridge with a two-stage registered
// memory model behind the IO port (data valid READ_LAT CLKs after launch).
module tb_bus_bridge;

    logic        CLK = 1'b0;
    logic        RESET_n;
    logic        PHI2;
    logic [15:0] CPU_A;
    logic [7:0]  CPU_DO;
    logic        CPU_R_W_n;
    logic [7:0]  CPU_DI;
    logic        RDY;
    logic [15:0] A;
    logic [7:0]  DI;
    logic        R_W_n;
    logic [7:0]  IO_DO = 8'h00;
    logic        OVERRUN;

    logic [7:0]  mem [0:65535];
    logic [7:0]  rd_s1 = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;
    int low_cnt;
    int low_at;
    logic [7:0] exp_di;
    logic       exp_rdy;

    bus_bridge dut (
        .CLK       (CLK),
        .RESET_n   (RESET_n),
        .PHI2      (PHI2),
        .CPU_A     (CPU_A),
        .CPU_DO    (CPU_DO),
        .CPU_R_W_n (CPU_R_W_n),
        .CPU_DI    (CPU_DI),
        .RDY       (RDY),
        .A         (A),
        .DI        (DI),
        .R_W_n     (R_W_n),
        .IO_DO     (IO_DO),
        .OVERRUN   (OVERRUN)
    );

    always #5 CLK = ~CLK;

    // Memory/IO model: sync read + registered output mux, write on strobe
    always @(posedge CLK) begin
        rd_s1 <= mem[A];
        IO_DO <= rd_s1;
        if (R_W_n == 1'b0) begin
            mem[A] <= DI;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [15:0] addr);
        CPU_A     = addr;
        CPU_R_W_n = 1'b1;
        PHI2      = 1'b1;
        cyc(6);
        PHI2      = 1'b0;
        cyc(3);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hE000] = 8'h4C;
        mem[16'hC000] = 8'hA7;
        mem[16'h0020] = 8'hEE;

        RESET_n = 1'b0; PHI2 = 1'b0; CPU_A = 16'h0000; CPU_DO = 8'h00; CPU_R_W_n = 1'b1;
        cyc(3);
        chk("reset_A",       16'(A),       16'h0000);
        chk("reset_DI",      16'(DI),      16'h0000);
        chk("reset_CPU_DI",  16'(CPU_DI),  16'h0000);
        chk("reset_R_W_n",   16'(R_W_n),   16'h0001);
        chk("reset_RDY",     16'(RDY),     16'h0001);
        chk("reset_OVERRUN", 16'(OVERRUN), 16'h0000);
        RESET_n = 1'b1;
        cyc(2);

        // 1: ROM read E000 -> 4C, capture after edge n+4
        CPU_A = 16'hE000; CPU_R_W_n = 1'b1; PHI2 = 1'b1;
        cyc(1);                                   // edge n
        chk("t1_A_not_yet", A, 16'h0000);
        cyc(1);                                   // n+1
        chk("t1_A_launch", A, 16'hE000);
        chk("t1_no_strobe", 16'(R_W_n), 16'h0001);
        cyc(2);                                   // n+3
        chk("t1_di_before", 16'(CPU_DI), 16'h0000);
        cyc(1);                                   // n+4
        chk("t1_di_capture", 16'(CPU_DI), 16'h004C);
        cyc(1);                                   // n+5
        PHI2 = 1'b0;
        cyc(3);

        // 2: write 5A to 0010 with PHI2 high 10 CLK
        CPU_A = 16'h0010; CPU_DO = 8'h5A; CPU_R_W_n = 1'b0; PHI2 = 1'b1;
        low_cnt = 0; low_at = -1;
        for (int i = 0; i < 13; i++) begin
            if (i == 10) PHI2 = 1'b0;
            cyc(1);
            if (R_W_n == 1'b0) begin
                low_cnt++;
                low_at = i;
            end
        end
        chk("t2_strobe_count", 16'(low_cnt), 16'd1);
        chk("t2_strobe_edge",  16'(low_at),  16'd1);
        chk("t2_DI",           16'(DI),      16'h005A);
        chk("t2_CPU_DI_kept",  16'(CPU_DI),  16'h004C);
        do_read(16'h0010);
        chk("t2_readback", 16'(CPU_DI), 16'h005A);

        // 3/4: UART read C000 -> A7, PHI2 high 10 CLK
        CPU_A = 16'hC000; CPU_R_W_n = 1'b1; PHI2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);                               // edge n+i
`ifdef WAIT_STATE_EN
            exp_rdy = (i >= 1 && i <= 7) ? 1'b0 : 1'b1;
            exp_di  = (i >= 8) ? 8'hA7 : 8'h5A;
`else
            exp_rdy = 1'b1;
            exp_di  = (i >= 4) ? 8'hA7 : 8'h5A;
`endif
            chk($sformatf("t34_RDY_%0d", i),    16'(RDY),    16'(exp_rdy));
            chk($sformatf("t34_CPU_DI_%0d", i), 16'(CPU_DI), 16'(exp_di));
        end
        PHI2 = 1'b0;
        cyc(3);

        // 5: PHI2 high only 2 CLK -> OVERRUN, capture still completes
        CPU_A = 16'hE000; CPU_R_W_n = 1'b1; PHI2 = 1'b1;
        cyc(2);                                   // edges n, n+1
        PHI2 = 1'b0;
        cyc(1);                                   // n+2
        chk("t5_ovr_not_yet", 16'(OVERRUN), 16'h0000);
        cyc(1);                                   // n+3
        chk("t5_ovr_set", 16'(OVERRUN), 16'h0001);
        chk("t5_di_before", 16'(CPU_DI), 16'h00A7);
        cyc(1);                                   // n+4
        chk("t5_di_capture", 16'(CPU_DI), 16'h004C);
        chk("t5_rdy", 16'(RDY), 16'h0001);
        cyc(3);
        do_read(16'h0010);
        chk("t5_next_read", 16'(CPU_DI), 16'h005A);
        chk("t5_ovr_sticky", 16'(OVERRUN), 16'h0001);

        // 6: reset during write strobe
        CPU_A = 16'h0020; CPU_DO = 8'h33; CPU_R_W_n = 1'b0; PHI2 = 1'b1;
        cyc(2);                                   // n+1: strobe active
        chk("t6_strobe", 16'(R_W_n), 16'h0000);
        RESET_n = 1'b0;
        #1;
        chk("t6_strobe_dropped", 16'(R_W_n), 16'h0001);
        cyc(1);                                   // reset edge
        chk("t6_A",       A,                 16'h0000);
        chk("t6_DI",      16'(DI),           16'h0000);
        chk("t6_CPU_DI",  16'(CPU_DI),       16'h0000);
        chk("t6_R_W_n",   16'(R_W_n),        16'h0001);
        chk("t6_RDY",     16'(RDY),          16'h0001);
        chk("t6_OVERRUN", 16'(OVERRUN),      16'h0000);
        PHI2 = 1'b0;
        cyc(1);
        RESET_n = 1'b1;
        cyc(2);
        do_read(16'h0020);
        chk("t6_no_write", 16'(CPU_DI), 16'h00EE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
